startup_seq: RTL and testbench

//  Power-up/power-down sequencer for N switched stages sharing one gated clock.

---
 rtl/startup_seq_pkg.sv | 27 ++
 rtl/startup_seq_timer.sv | 46 ++++
 rtl/startup_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_startup_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/startup_seq_pkg.sv
// -----------------------------------------------------------------------------
// startup_seq_pkg
// Shared definitions for the power-up/power-down sequencer:
//   - FSM state encodings (3-bit, plain localparams for legacy tool compatibility)
//   - timer_w(): width of the shared pulse/timeout down-counter
// -----------------------------------------------------------------------------
package startup_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_CLKON    = 3'd1;
    localparam state_t ST_PULSE    = 3'd2;
    localparam state_t ST_SETTLE   = 3'd3;
    localparam state_t ST_READY    = 3'd4;
    localparam state_t ST_SHUTDOWN = 3'd5;
    localparam state_t ST_FAULT    = 3'd6;

    // One counter serves both the strobe width and the ack timeout, so it must
    // hold the larger of the two load values (each is loaded as value-1).
    function automatic int timer_w(input int pulse_cyc, input int timeout_cyc);
        int m;
        m = (pulse_cyc > timeout_cyc) ? pulse_cyc : timeout_cyc;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/startup_seq_timer.sv
// -----------------------------------------------------------------------------
// seq_timer
// Loadable down-counter that saturates at zero.
// Ports:
//   clk       in  system clock
//   rst_n     in  async active-low reset (counter -> 0)
//   load      in  load load_val on this edge (takes priority over counting)
//   load_val  in  value to load
//   value     out current count
//   done      out count is zero
// -----------------------------------------------------------------------------
module seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign done  = (cnt_q == '0);

endmodule

// File: rtl/startup_seq.sv
// -----------------------------------------------------------------------------
// startup_seq
// Power-up/power-down sequencer for N_STAGES switched stages on one gated clock.
// Turns the stage clock on, then strobes each stage's switch in order and waits
// for its ack; tears stages down highest-first on stop; latches a sticky fault
// when an ack does not arrive in time.
// Ports:
//   clk       in   system clock
//   rst_n     in   async active-low reset
//   start     in   power-up request (only looked at in IDLE)
//   stop      in   power-down / abort / fault-clear, wins over start
//   ack       in   per-stage powered acknowledge (level)
//   clk_en    out  stage clock enable
//   sw_on     out  one-hot switch-on strobe, PULSE_CYC cycles wide
//   stage_on  out  per-stage enable level
//   ready     out  all stages up
//   fault     out  sticky ack-timeout flag
//   busy      out  sequencing in progress (CLKON/PULSE/SETTLE/SHUTDOWN)
// -----------------------------------------------------------------------------
module startup_seq
    import startup_seq_pkg::*;
#(
    parameter int N_STAGES    = 4,
    parameter int PULSE_CYC   = 2,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [N_STAGES-1:0] ack,
    output logic                clk_en,
    output logic [N_STAGES-1:0] sw_on,
    output logic [N_STAGES-1:0] stage_on,
    output logic                ready,
    output logic                fault,
    output logic                busy
);

    localparam int TW    = timer_w(PULSE_CYC, TIMEOUT_CYC);
    localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [N_STAGES-1:0] ONE       = N_STAGES'(1);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(N_STAGES - 1);
    localparam logic [TW-1:0]       PULSE_LD  = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0]       TIMEOUT_LD = TW'(TIMEOUT_CYC - 1);

    state_t              state_q,    state_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic                clk_en_q,   clk_en_d;
    logic [N_STAGES-1:0] sw_on_q,    sw_on_d;
    logic [N_STAGES-1:0] stage_on_q, stage_on_d;
    logic                ready_q,    ready_d;
    logic                fault_q,    fault_d;

    logic                tmr_load;
    logic [TW-1:0]       tmr_val;
    logic [TW-1:0]       tmr_value;
    logic                tmr_done;
    logic [IDX_W-1:0]    nxt_idx;

    seq_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value),
        .done     (tmr_done)
    );

    // Teardown removes one stage per cycle, newest (highest) stage first.
    function automatic logic [N_STAGES-1:0] clr_highest(input logic [N_STAGES-1:0] v);
        logic [N_STAGES-1:0] r;
        logic                found;
        r     = v;
        found = 1'b0;
        for (int i = N_STAGES - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                r[i]  = 1'b0;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign nxt_idx = idx_q + IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        clk_en_d   = clk_en_q;
        sw_on_d    = sw_on_q;
        stage_on_d = stage_on_q;
        ready_d    = ready_q;
        fault_d    = fault_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d  = ST_CLKON;
                    clk_en_d = 1'b1;
                end
            end

            ST_CLKON: begin
                if (stop) begin
                    state_d = ST_SHUTDOWN;
                    sw_on_d = '0;
                end else begin
                    state_d    = ST_PULSE;
                    idx_d      = '0;
                    sw_on_d    = ONE;
                    stage_on_d = stage_on_q | ONE;
                    tmr_load   = 1'b1;
                    tmr_val    = PULSE_LD;
                end
            end

            ST_PULSE: begin
                if (stop) begin
                    state_d = ST_SHUTDOWN;
                    sw_on_d = '0;
                end else if (tmr_done) begin
                    state_d  = ST_SETTLE;
                    sw_on_d  = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TIMEOUT_LD;
                end
            end

            ST_SETTLE: begin
                if (stop) begin
                    state_d = ST_SHUTDOWN;
                    sw_on_d = '0;
                end else if (ack[idx_q]) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_READY;
                        ready_d = 1'b1;
                    end else begin
                        state_d    = ST_PULSE;
                        idx_d      = nxt_idx;
                        sw_on_d    = ONE << nxt_idx;
                        stage_on_d = stage_on_q | (ONE << nxt_idx);
                        tmr_load   = 1'b1;
                        tmr_val    = PULSE_LD;
                    end
                end else if (tmr_done) begin
                    // Timed out: drop everything at once, no ordered teardown.
                    state_d    = ST_FAULT;
                    fault_d    = 1'b1;
                    stage_on_d = '0;
                    clk_en_d   = 1'b0;
                    sw_on_d    = '0;
                end
            end

            ST_READY: begin
                if (stop) begin
                    state_d = ST_SHUTDOWN;
                    ready_d = 1'b0;
                end
            end

            ST_SHUTDOWN: begin
                // Clock stays on until the cycle after the last stage is off.
                if (stage_on_q == '0) begin
                    state_d  = ST_IDLE;
                    clk_en_d = 1'b0;
                    idx_d    = '0;
                end else begin
                    stage_on_d = clr_highest(stage_on_q);
                end
            end

            ST_FAULT: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b0;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                idx_d      = '0;
                clk_en_d   = 1'b0;
                sw_on_d    = '0;
                stage_on_d = '0;
                ready_d    = 1'b0;
                fault_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            clk_en_q   <= 1'b0;
            sw_on_q    <= '0;
            stage_on_q <= '0;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            clk_en_q   <= clk_en_d;
            sw_on_q    <= sw_on_d;
            stage_on_q <= stage_on_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
        end
    end

    assign clk_en   = clk_en_q;
    assign sw_on    = sw_on_q;
    assign stage_on = stage_on_q;
    assign ready    = ready_q;
    assign fault    = fault_q;
    assign busy     = (state_q == ST_CLKON)  || (state_q == ST_PULSE) ||
                      (state_q == ST_SETTLE) || (state_q == ST_SHUTDOWN);

endmodule

// File: tb/tb_startup_seq.sv
// -----------------------------------------------------------------------------
// tb_startup_seq
// Self-checking bench for startup_seq (default parameters, 4 stages).
// Expected outputs are packed as {clk_en, sw_on[3:0], stage_on[3:0], ready,
// fault, busy}; each step queues its expectation and checks it after the edge.
// -----------------------------------------------------------------------------
module tb_startup_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [3:0] ack;
    logic       clk_en;
    logic [3:0] sw_on;
    logic [3:0] stage_on;
    logic       ready;
    logic       fault;
    logic       busy;

    startup_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .ack      (ack),
        .clk_en   (clk_en),
        .sw_on    (sw_on),
        .stage_on (stage_on),
        .ready    (ready),
        .fault    (fault),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic [3:0] ack;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        int          tid;
        int          stp;
        logic [11:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    vec_t t1[15];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [11:0] e(input logic ce, input logic [3:0] sw,
                                      input logic [3:0] st, input logic r,
                                      input logic f, input logic b);
        return {ce, sw, st, r, f, b};
    endfunction

    function automatic logic [11:0] outs();
        return {clk_en, sw_on, stage_on, ready, fault, busy};
    endfunction

    task automatic check_now(input string name, input logic [11:0] exp);
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, outs(), exp);
        end
    endtask

    // Drive inputs, queue the expectation, clock once, then compare.
    task automatic step(input int tid, input int stp, input logic s, input logic p,
                        input logic [3:0] a, input logic [11:0] exp);
        sb_t item;
        sb_t got;
        start = s;
        stop  = p;
        ack   = a;
        item.tid = tid;
        item.stp = stp;
        item.exp = exp;
        sb_q.push_back(item);
        @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL t%0d_e%0d scoreboard empty got=%h", tid, stp, outs());
        end else begin
            got = sb_q.pop_front();
            if (outs() !== got.exp) begin
                failures++;
                $display("FAIL t%0d_e%0d got=%h expected=%h", got.tid, got.stp, outs(), got.exp);
            end
        end
    endtask

    task automatic run_t1(input int tid);
        for (int i = 0; i < 15; i++) begin
            step(tid, i, t1[i].start, t1[i].stop, t1[i].ack, t1[i].exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Nominal power-up with all acks high; edge index = entry index.
        t1[0]  = '{1'b1, 1'b0, 4'hF, e(1, 4'h0, 4'h0, 0, 0, 1)};
        t1[1]  = '{1'b0, 1'b0, 4'hF, e(1, 4'h1, 4'h1, 0, 0, 1)};
        t1[2]  = '{1'b0, 1'b0, 4'hF, e(1, 4'h1, 4'h1, 0, 0, 1)};
        t1[3]  = '{1'b0, 1'b0, 4'hF, e(1, 4'h0, 4'h1, 0, 0, 1)};
        t1[4]  = '{1'b0, 1'b0, 4'hF, e(1, 4'h2, 4'h3, 0, 0, 1)};
        t1[5]  = '{1'b0, 1'b0, 4'hF, e(1, 4'h2, 4'h3, 0, 0, 1)};
        t1[6]  = '{1'b0, 1'b0, 4'hF, e(1, 4'h0, 4'h3, 0, 0, 1)};
        t1[7]  = '{1'b0, 1'b0, 4'hF, e(1, 4'h4, 4'h7, 0, 0, 1)};
        t1[8]  = '{1'b0, 1'b0, 4'hF, e(1, 4'h4, 4'h7, 0, 0, 1)};
        t1[9]  = '{1'b0, 1'b0, 4'hF, e(1, 4'h0, 4'h7, 0, 0, 1)};
        t1[10] = '{1'b0, 1'b0, 4'hF, e(1, 4'h8, 4'hF, 0, 0, 1)};
        t1[11] = '{1'b0, 1'b0, 4'hF, e(1, 4'h8, 4'hF, 0, 0, 1)};
        t1[12] = '{1'b0, 1'b0, 4'hF, e(1, 4'h0, 4'hF, 0, 0, 1)};
        t1[13] = '{1'b0, 1'b0, 4'hF, e(1, 4'h0, 4'hF, 1, 0, 0)};
        t1[14] = '{1'b0, 1'b0, 4'hF, e(1, 4'h0, 4'hF, 1, 0, 0)};

        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        ack   = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_state", e(0, 4'h0, 4'h0, 0, 0, 0));
        rst_n = 1'b1;

        // 1: full power-up
        run_t1(1);

        // 5b: start while READY is ignored
        step(5, 0, 1'b1, 1'b0, 4'hF, e(1, 4'h0, 4'hF, 1, 0, 0));
        step(5, 1, 1'b0, 1'b0, 4'hF, e(1, 4'h0, 4'hF, 1, 0, 0));

        // 3: ordered shutdown from READY
        step(3, 0, 1'b0, 1'b1, 4'hF, e(1, 4'h0, 4'hF, 0, 0, 1));
        step(3, 1, 1'b0, 1'b0, 4'hF, e(1, 4'h0, 4'h7, 0, 0, 1));
        step(3, 2, 1'b0, 1'b0, 4'hF, e(1, 4'h0, 4'h3, 0, 0, 1));
        step(3, 3, 1'b0, 1'b0, 4'hF, e(1, 4'h0, 4'h1, 0, 0, 1));
        step(3, 4, 1'b0, 1'b0, 4'hF, e(1, 4'h0, 4'h0, 0, 0, 1));
        step(3, 5, 1'b0, 1'b0, 4'hF, e(0, 4'h0, 4'h0, 0, 0, 0));

        // 5a: start and stop together in IDLE do nothing
        step(5, 2, 1'b1, 1'b1, 4'hF, e(0, 4'h0, 4'h0, 0, 0, 0));
        step(5, 3, 1'b0, 1'b0, 4'hF, e(0, 4'h0, 4'h0, 0, 0, 0));

        // 2: stage 2 never acks -> timeout fault, then clear with stop
        step(2, 0, 1'b1, 1'b0, 4'hB, e(1, 4'h0, 4'h0, 0, 0, 1));
        step(2, 1, 1'b0, 1'b0, 4'hB, e(1, 4'h1, 4'h1, 0, 0, 1));
        step(2, 2, 1'b0, 1'b0, 4'hB, e(1, 4'h1, 4'h1, 0, 0, 1));
        step(2, 3, 1'b0, 1'b0, 4'hB, e(1, 4'h0, 4'h1, 0, 0, 1));
        step(2, 4, 1'b0, 1'b0, 4'hB, e(1, 4'h2, 4'h3, 0, 0, 1));
        step(2, 5, 1'b0, 1'b0, 4'hB, e(1, 4'h2, 4'h3, 0, 0, 1));
        step(2, 6, 1'b0, 1'b0, 4'hB, e(1, 4'h0, 4'h3, 0, 0, 1));
        step(2, 7, 1'b0, 1'b0, 4'hB, e(1, 4'h4, 4'h7, 0, 0, 1));
        step(2, 8, 1'b0, 1'b0, 4'hB, e(1, 4'h4, 4'h7, 0, 0, 1));
        step(2, 9, 1'b0, 1'b0, 4'hB, e(1, 4'h0, 4'h7, 0, 0, 1));
        for (int k = 10; k <= 23; k++) begin
            step(2, k, 1'b0, 1'b0, 4'hB, e(1, 4'h0, 4'h7, 0, 0, 1));
        end
        step(2, 24, 1'b0, 1'b0, 4'hB, e(0, 4'h0, 4'h0, 0, 1, 0));
        step(2, 25, 1'b1, 1'b0, 4'hF, e(0, 4'h0, 4'h0, 0, 1, 0));
        step(2, 26, 1'b0, 1'b1, 4'hF, e(0, 4'h0, 4'h0, 0, 0, 0));
        step(2, 27, 1'b0, 1'b0, 4'hF, e(0, 4'h0, 4'h0, 0, 0, 0));

        // 4: abort while stage 1 is being strobed
        step(4, 0, 1'b1, 1'b0, 4'hF, e(1, 4'h0, 4'h0, 0, 0, 1));
        step(4, 1, 1'b0, 1'b0, 4'hF, e(1, 4'h1, 4'h1, 0, 0, 1));
        step(4, 2, 1'b0, 1'b0, 4'hF, e(1, 4'h1, 4'h1, 0, 0, 1));
        step(4, 3, 1'b0, 1'b0, 4'hF, e(1, 4'h0, 4'h1, 0, 0, 1));
        step(4, 4, 1'b0, 1'b0, 4'hF, e(1, 4'h2, 4'h3, 0, 0, 1));
        step(4, 5, 1'b0, 1'b1, 4'hF, e(1, 4'h0, 4'h3, 0, 0, 1));
        step(4, 6, 1'b0, 1'b0, 4'hF, e(1, 4'h0, 4'h1, 0, 0, 1));
        step(4, 7, 1'b0, 1'b0, 4'hF, e(1, 4'h0, 4'h0, 0, 0, 1));
        step(4, 8, 1'b0, 1'b0, 4'hF, e(0, 4'h0, 4'h0, 0, 0, 0));
        step(4, 9, 1'b0, 1'b0, 4'hF, e(0, 4'h0, 4'h0, 0, 0, 0));

        // 6: async reset mid-SETTLE, then a clean restart
        step(6, 100, 1'b1, 1'b0, 4'h0, e(1, 4'h0, 4'h0, 0, 0, 1));
        step(6, 101, 1'b0, 1'b0, 4'h0, e(1, 4'h1, 4'h1, 0, 0, 1));
        step(6, 102, 1'b0, 1'b0, 4'h0, e(1, 4'h1, 4'h1, 0, 0, 1));
        step(6, 103, 1'b0, 1'b0, 4'h0, e(1, 4'h0, 4'h1, 0, 0, 1));
        step(6, 104, 1'b0, 1'b0, 4'h0, e(1, 4'h0, 4'h1, 0, 0, 1));
        rst_n = 1'b0;
        #2;
        check_now("async_reset_mid_settle", e(0, 4'h0, 4'h0, 0, 0, 0));
        @(posedge clk);
        #1;
        check_now("reset_held", e(0, 4'h0, 4'h0, 0, 0, 0));
        rst_n = 1'b1;
        run_t1(6);

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
